// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code decoder: FSM encoding,
// prefix/shift byte constants and the list of bytes dropped in IDLE.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] LSHIFT  = 8'h12;
  localparam logic [7:0] RSHIFT  = 8'h59;

  // Keyboard housekeeping bytes (BAT, echo, ack, resend, errors).
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default:                                  is_ignored = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational Set-2 code to ASCII lookup for non-extended keys.
// Letters follow shift; digits and control keys do not.
module ps2_ascii_rom (
  input  logic [7:0] code_i,
  input  logic       shift_i,
  output logic [7:0] ascii_o
);

  logic [7:0] letter;
  logic [7:0] other;

  always_comb begin
    letter = 8'h00;
    case (code_i)
      8'h1C: letter = "a";
      8'h32: letter = "b";
      8'h21: letter = "c";
      8'h23: letter = "d";
      8'h24: letter = "e";
      8'h2B: letter = "f";
      8'h34: letter = "g";
      8'h33: letter = "h";
      8'h43: letter = "i";
      8'h3B: letter = "j";
      8'h42: letter = "k";
      8'h4B: letter = "l";
      8'h3A: letter = "m";
      8'h31: letter = "n";
      8'h44: letter = "o";
      8'h4D: letter = "p";
      8'h15: letter = "q";
      8'h2D: letter = "r";
      8'h1B: letter = "s";
      8'h2C: letter = "t";
      8'h3C: letter = "u";
      8'h2A: letter = "v";
      8'h1D: letter = "w";
      8'h22: letter = "x";
      8'h35: letter = "y";
      8'h1A: letter = "z";
      default: letter = 8'h00;
    endcase
  end

  always_comb begin
    other = 8'h00;
    case (code_i)
      8'h45: other = "0";
      8'h16: other = "1";
      8'h1E: other = "2";
      8'h26: other = "3";
      8'h25: other = "4";
      8'h2E: other = "5";
      8'h36: other = "6";
      8'h3D: other = "7";
      8'h3E: other = "8";
      8'h46: other = "9";
      8'h29: other = 8'h20;
      8'h5A: other = 8'h0D;
      8'h66: other = 8'h08;
      8'h76: other = 8'h1B;
      default: other = 8'h00;
    endcase
  end

  always_comb begin
    if (letter != 8'h00) ascii_o = shift_i ? (letter - 8'h20) : letter;
    else                 ascii_o = other;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns raw Set-2 scan-code bytes into registered single-cycle key events,
// tracking shift, the held key and a count of new keypresses.
//
// state      | meaning
// -----------+-----------------------------------------
// ST_IDLE    | no prefix pending
// ST_EXT     | seen E0, waiting for code (or F0)
// ST_BRK     | seen F0, waiting for released code
// ST_EXT_BRK | seen E0 F0, waiting for released ext code
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_repeat,
  output logic [7:0]       ev_ascii,
  output logic [CNT_W-1:0] key_count,
  output logic             held,
  output logic [8:0]       held_code,
  output logic             shift
);

  ps2_state_e       state_q, state_d;
  logic             ev_valid_q, ev_ext_q, ev_break_q, ev_repeat_q;
  logic [7:0]       ev_code_q, ev_ascii_q;
  logic             ev_ext_d, ev_break_d, ev_repeat_d;
  logic [7:0]       ev_code_d, ev_ascii_d;
  logic             fire;
  logic [CNT_W-1:0] count_q, count_d;
  logic             held_q, held_d;
  logic [8:0]       held_code_q, held_code_d;
  logic             lshift_q, lshift_d, rshift_q, rshift_d;
  logic [8:0]       key;
  logic [7:0]       rom_ascii;

  // Case decision uses shift as it stood before this byte's edge.
  ps2_ascii_rom u_rom (
    .code_i  (in_data),
    .shift_i (lshift_q | rshift_q),
    .ascii_o (rom_ascii)
  );

  always_comb begin
    state_d     = state_q;
    fire        = 1'b0;
    ev_ext_d    = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    ev_break_d  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    key         = {ev_ext_d, in_data};
    ev_code_d   = in_data;
    ev_repeat_d = !ev_break_d && held_q && (held_code_q == key);
    ev_ascii_d  = ev_ext_d ? 8'h00 : rom_ascii;
    count_d     = count_q;
    held_d      = held_q;
    held_code_d = held_code_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;

    if (in_valid) begin
      if (in_data == PS2_EXT) begin
        state_d = ST_EXT;
      end else if (in_data == PS2_BRK) begin
        if (state_q == ST_IDLE)     state_d = ST_BRK;
        else if (state_q == ST_EXT) state_d = ST_EXT_BRK;
      end else if (!(state_q == ST_IDLE && is_ignored(in_data))) begin
        fire    = 1'b1;
        state_d = ST_IDLE;
      end
    end

    if (fire) begin
      if (!ev_break_d) begin
        if (!ev_repeat_d) count_d = count_q + CNT_W'(1);
        held_d      = 1'b1;
        held_code_d = key;
      end else if (held_code_q == key) begin
        held_d = 1'b0;
      end
      if (!ev_ext_d && in_data == LSHIFT) lshift_d = !ev_break_d;
      if (!ev_ext_d && in_data == RSHIFT) rshift_d = !ev_break_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ev_valid_q  <= 1'b0;
      ev_code_q   <= 8'h00;
      ev_ext_q    <= 1'b0;
      ev_break_q  <= 1'b0;
      ev_repeat_q <= 1'b0;
      ev_ascii_q  <= 8'h00;
      count_q     <= '0;
      held_q      <= 1'b0;
      held_code_q <= 9'h000;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ev_valid_q <= fire;
      if (fire) begin
        ev_code_q   <= ev_code_d;
        ev_ext_q    <= ev_ext_d;
        ev_break_q  <= ev_break_d;
        ev_repeat_q <= ev_repeat_d;
        ev_ascii_q  <= ev_ascii_d;
      end
      count_q     <= count_d;
      held_q      <= held_d;
      held_code_q <= held_code_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
    end
  end

  assign ev_valid  = ev_valid_q;
  assign ev_code   = ev_code_q;
  assign ev_ext    = ev_ext_q;
  assign ev_break  = ev_break_q;
  assign ev_repeat = ev_repeat_q;
  assign ev_ascii  = ev_ascii_q;
  assign key_count = count_q;
  assign held      = held_q;
  assign held_code = held_code_q;
  assign shift     = lshift_q | rshift_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ev_valid, ev_ext, ev_break, ev_repeat, held, shift;
  logic [7:0] ev_code, ev_ascii, key_count;
  logic [8:0] held_code;

  int errors = 0;
  int checks = 0;

  ps2_scancode_decoder #(.CNT_W(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_break  (ev_break),
    .ev_repeat (ev_repeat),
    .ev_ascii  (ev_ascii),
    .key_count (key_count),
    .held      (held),
    .held_code (held_code),
    .shift     (shift)
  );

  always #5 clk = ~clk;

  // Presents one byte for one cycle; returns #1 after the capturing edge.
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    idle();
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got=%b exp=0", ev_valid); end
    checks++; if ({ev_code, ev_ascii} !== 16'h0) begin errors++; $display("FAIL reset_ev_fields got=%h exp=0000", {ev_code, ev_ascii}); end
    checks++; if ({ev_ext, ev_break, ev_repeat} !== 3'b000) begin errors++; $display("FAIL reset_ev_flags got=%b exp=000", {ev_ext, ev_break, ev_repeat}); end
    checks++; if (key_count !== 8'h00) begin errors++; $display("FAIL reset_count got=%h exp=00", key_count); end
    checks++; if ({held, held_code, shift} !== 11'h0) begin errors++; $display("FAIL reset_held got=%h exp=000", {held, held_code, shift}); end
    resetn = 1'b1;
    idle();
  endtask

  task automatic test_make_break;
    do_reset();
    send(8'h1C);
    checks++; if ({ev_valid, ev_code, ev_break, ev_ext} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin errors++; $display("FAIL mb_make got=%b/%h/%b/%b exp=1/1c/0/0", ev_valid, ev_code, ev_break, ev_ext); end
    checks++; if ({ev_ascii, key_count, held} !== {8'h61, 8'h01, 1'b1}) begin errors++; $display("FAIL mb_make_state got=%h/%h/%b exp=61/01/1", ev_ascii, key_count, held); end
    send(8'hF0);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL mb_prefix_no_event got=%b exp=0", ev_valid); end
    send(8'h1C);
    checks++; if ({ev_valid, ev_break, ev_ascii, held} !== {1'b1, 1'b1, 8'h61, 1'b0}) begin errors++; $display("FAIL mb_break got=%b/%b/%h/%b exp=1/1/61/0", ev_valid, ev_break, ev_ascii, held); end
    checks++; if (key_count !== 8'h01) begin errors++; $display("FAIL mb_break_count got=%h exp=01", key_count); end
  endtask

  task automatic test_shift;
    do_reset();
    send(8'h12);
    checks++; if ({ev_valid, ev_ascii, shift, key_count} !== {1'b1, 8'h00, 1'b1, 8'h01}) begin errors++; $display("FAIL sh_make got=%b/%h/%b/%h exp=1/00/1/01", ev_valid, ev_ascii, shift, key_count); end
    send(8'h1C);
    checks++; if ({ev_ascii, ev_repeat, key_count} !== {8'h41, 1'b0, 8'h02}) begin errors++; $display("FAIL sh_upper got=%h/%b/%h exp=41/0/02", ev_ascii, ev_repeat, key_count); end
    send(8'h1C);
    checks++; if ({ev_valid, ev_ascii, ev_repeat, key_count} !== {1'b1, 8'h41, 1'b1, 8'h02}) begin errors++; $display("FAIL sh_repeat got=%b/%h/%b/%h exp=1/41/1/02", ev_valid, ev_ascii, ev_repeat, key_count); end
    send(8'hF0); send(8'h1C);
    checks++; if ({ev_break, ev_ascii, held, held_code} !== {1'b1, 8'h41, 1'b0, 9'h01C}) begin errors++; $display("FAIL sh_break got=%b/%h/%b/%h exp=1/41/0/01c", ev_break, ev_ascii, held, held_code); end
    send(8'hF0); send(8'h12);
    checks++; if ({ev_valid, ev_break, ev_ascii, shift, key_count} !== {1'b1, 1'b1, 8'h00, 1'b0, 8'h02}) begin errors++; $display("FAIL sh_release got=%b/%b/%h/%b/%h exp=1/1/00/0/02", ev_valid, ev_break, ev_ascii, shift, key_count); end
    send(8'h59); send(8'h46);
    checks++; if ({ev_ascii, shift} !== {8'h39, 1'b1}) begin errors++; $display("FAIL sh_digit_unshifted got=%h/%b exp=39/1", ev_ascii, shift); end
    send(8'h1A);
    checks++; if (ev_ascii !== 8'h5A) begin errors++; $display("FAIL sh_rshift_upper got=%h exp=5a", ev_ascii); end
  endtask

  task automatic test_extended;
    do_reset();
    send(8'hE0);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ext_prefix got=%b exp=0", ev_valid); end
    send(8'h75);
    checks++; if ({ev_valid, ev_code, ev_ext, ev_break, ev_ascii} !== {1'b1, 8'h75, 1'b1, 1'b0, 8'h00}) begin errors++; $display("FAIL ext_make got=%b/%h/%b/%b/%h exp=1/75/1/0/00", ev_valid, ev_code, ev_ext, ev_break, ev_ascii); end
    checks++; if ({held, held_code} !== {1'b1, 9'h175}) begin errors++; $display("FAIL ext_held got=%b/%h exp=1/175", held, held_code); end
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++; if ({ev_valid, ev_ext, ev_break, held} !== 4'b1110) begin errors++; $display("FAIL ext_break got=%b exp=1110", {ev_valid, ev_ext, ev_break, held}); end
    send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h1C);
    checks++; if ({ev_ext, ev_break, ev_ascii, held} !== {1'b1, 1'b1, 8'h00, 1'b1}) begin errors++; $display("FAIL ext_nonmatch_break got=%b/%b/%h/%b exp=1/1/00/1", ev_ext, ev_break, ev_ascii, held); end
  endtask

  task automatic test_ignore_restart;
    do_reset();
    send(8'hAA);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ign_aa got=%b exp=0", ev_valid); end
    send(8'hFA);
    checks++; if ({ev_valid, key_count} !== {1'b0, 8'h00}) begin errors++; $display("FAIL ign_fa got=%b/%h exp=0/00", ev_valid, key_count); end
    send(8'hF0); send(8'hE0);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ign_restart_prefix got=%b exp=0", ev_valid); end
    send(8'h74);
    checks++; if ({ev_valid, ev_code, ev_ext, ev_break} !== {1'b1, 8'h74, 1'b1, 1'b0}) begin errors++; $display("FAIL ign_restart got=%b/%h/%b/%b exp=1/74/1/0", ev_valid, ev_code, ev_ext, ev_break); end
    send(8'hF0); send(8'hF0); send(8'h29);
    checks++; if ({ev_valid, ev_ext, ev_break, ev_ascii} !== {1'b1, 1'b0, 1'b1, 8'h20}) begin errors++; $display("FAIL brk_hold got=%b/%b/%b/%h exp=1/0/1/20", ev_valid, ev_ext, ev_break, ev_ascii); end
    send(8'hF0); send(8'hAA);
    checks++; if ({ev_valid, ev_code, ev_break} !== {1'b1, 8'hAA, 1'b1}) begin errors++; $display("FAIL brk_not_ignored got=%b/%h/%b exp=1/aa/1", ev_valid, ev_code, ev_break); end
  endtask

  task automatic test_ascii_table;
    logic [7:0] codes [7];
    logic [7:0] exp   [7];
    codes = '{8'h1A, 8'h29, 8'h5A, 8'h66, 8'h76, 8'h4D, 8'h3E};
    exp   = '{8'h7A, 8'h20, 8'h0D, 8'h08, 8'h1B, 8'h70, 8'h38};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(codes[i]);
      checks++; if ({ev_valid, ev_ascii} !== {1'b1, exp[i]}) begin errors++; $display("FAIL ascii_%h got=%b/%h exp=1/%h", codes[i], ev_valid, ev_ascii, exp[i]); end
      send(8'hF0); send(codes[i]);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    send(8'h45);
    checks++; if ({ev_valid, ev_code, ev_ascii} !== {1'b1, 8'h45, 8'h30}) begin errors++; $display("FAIL b2b_0 got=%b/%h/%h exp=1/45/30", ev_valid, ev_code, ev_ascii); end
    send(8'h16);
    checks++; if ({ev_valid, ev_code, ev_ascii} !== {1'b1, 8'h16, 8'h31}) begin errors++; $display("FAIL b2b_1 got=%b/%h/%h exp=1/16/31", ev_valid, ev_code, ev_ascii); end
    send(8'hF0);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL b2b_prefix got=%b exp=0", ev_valid); end
    send(8'h16);
    checks++; if ({ev_valid, ev_break, ev_ascii} !== {1'b1, 1'b1, 8'h31}) begin errors++; $display("FAIL b2b_break got=%b/%b/%h exp=1/1/31", ev_valid, ev_break, ev_ascii); end
    idle();
    checks++; if ({ev_valid, ev_code, ev_break} !== {1'b0, 8'h16, 1'b1}) begin errors++; $display("FAIL b2b_hold got=%b/%h/%b exp=0/16/1", ev_valid, ev_code, ev_break); end
    checks++; if (key_count !== 8'h02) begin errors++; $display("FAIL b2b_count got=%h exp=02", key_count); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    send(8'hF0);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    send(8'h1C);
    checks++; if ({ev_valid, ev_break, key_count, held} !== {1'b1, 1'b0, 8'h01, 1'b1}) begin errors++; $display("FAIL rst_mid got=%b/%b/%h/%b exp=1/0/01/1", ev_valid, ev_break, key_count, held); end
  endtask

  task automatic test_wrap;
    logic [7:0] c;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        checks++; if (key_count !== 8'hFF) begin errors++; $display("FAIL wrap_pre got=%h exp=ff", key_count); end
      end
      c = 8'(i % 100) + 8'h01;
      send(c);
      send(8'hF0);
      send(c);
    end
    checks++; if ({key_count, held, ev_repeat} !== {8'h00, 1'b0, 1'b0}) begin errors++; $display("FAIL wrap got=%h/%b/%b exp=00/0/0", key_count, held, ev_repeat); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_shift();
    test_extended();
    test_ignore_restart();
    test_ascii_table();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
